// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bus port between the inst-fetch and data masters.
// Arbitrates the address phase and routes in-order data responses via an owner FIFO.
module sram_port_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic          i_wr,
    input  logic [1:0]    i_size,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic          i_addr_ok,
    output logic          i_data_ok,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_addr_ok,
    output logic          d_data_ok,
    output logic [DW-1:0] d_rdata,
    output logic          s_req,
    output logic          s_wr,
    output logic [1:0]    s_size,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_addr_ok,
    input  logic          s_data_ok,
    input  logic [DW-1:0] s_rdata,
    output logic          err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } lock_e;

    lock_e             state;
    lock_e             state_nxt;
    logic              grant_d;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              head;
    logic [DEPTH-1:0]  owner_q;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Grant is live in IDLE (data priority) and pinned to the owner while locked
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        s_req     = 1'b0;
        case (state)
            IDLE:    grant_d = d_req;
            LOCK_I:  grant_d = 1'b0;
            LOCK_D:  grant_d = 1'b1;
            default: grant_d = 1'b0;
        endcase
        s_req = (grant_d ? d_req : i_req) & ~full;
        case (state)
            IDLE: begin
                if (s_req && !s_addr_ok) state_nxt = grant_d ? LOCK_D : LOCK_I;
            end
            LOCK_I, LOCK_D: begin
                if (s_addr_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_wr    = grant_d ? d_wr    : i_wr;
    assign s_size  = grant_d ? d_size  : i_size;
    assign s_addr  = grant_d ? d_addr  : i_addr;
    assign s_wdata = grant_d ? d_wdata : i_wdata;

    assign i_addr_ok = s_addr_ok & s_req & ~grant_d;
    assign d_addr_ok = s_addr_ok & s_req &  grant_d;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = s_req & s_addr_ok;
    assign pop   = s_data_ok & ~empty;
    assign head  = owner_q[rd_ptr];

    // Owner FIFO: one bit per outstanding transaction, 1 = data master
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr] <= grant_d;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign i_data_ok = pop & ~head;
    assign d_data_ok = pop &  head;
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;

    // Sticky flag for stray data responses or unrequested address accepts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) err <= 1'b0;
        else if ((s_data_ok && empty) || (s_addr_ok && !s_req)) err <= 1'b1;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed table-driven bench for sram_port_arbiter (DEPTH=4).
module tb_sram_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] IA = 32'h0000_1000;
    localparam logic [AW-1:0] DA = 32'h0000_2000;
    localparam logic [DW-1:0] IWD = 32'hAAAA_0001;
    localparam logic [DW-1:0] DWD = 32'hBBBB_0002;

    logic          clk;
    logic          resetn;
    logic          i_req, i_wr, d_req, d_wr;
    logic [1:0]    i_size, d_size, s_size;
    logic [AW-1:0] i_addr, d_addr, s_addr;
    logic [DW-1:0] i_wdata, d_wdata, s_wdata;
    logic          i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [DW-1:0] i_rdata, d_rdata, s_rdata;
    logic          s_req, s_wr, s_addr_ok, s_data_ok, err;

    int total;
    int bad;

    sram_port_arbiter #(.AW(AW), .DW(DW), .DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, dr, aok, dok;
        logic [31:0] rdata;
        logic        e_sreq, e_seld, e_iaok, e_daok, e_idok, e_ddok;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic ir, logic dr, logic aok, logic dok, logic [31:0] rd,
                                logic es, logic esd, logic eia, logic eda, logic eid, logic edd);
        vec_t v;
        v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.e_sreq = es; v.e_seld = esd; v.e_iaok = eia; v.e_daok = eda;
        v.e_idok = eid; v.e_ddok = edd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok,
                         input logic [31:0] rd);
        i_req = ir; d_req = dr; s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
    endtask

    initial begin
        total = 0; bad = 0;
        resetn = 1'b0;
        i_wr = 1'b0; i_size = 2'd2; i_addr = IA; i_wdata = IWD;
        d_wr = 1'b1; d_size = 2'd1; d_addr = DA; d_wdata = DWD;
        drive(0, 0, 0, 0, '0);

        // Test 2: simultaneous reqs, data wins, in-order responses d then i
        vq.push_back(mk(1,1,1,0,32'h0,  1,1,0,1,0,0));
        vq.push_back(mk(1,0,1,0,32'h0,  1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,1,32'hA1, 0,0,0,0,0,1));
        vq.push_back(mk(0,0,0,1,32'hA2, 0,0,0,0,1,0));
        // Test 3: inst locked through 3 stalled cycles while d_req rises
        vq.push_back(mk(1,0,0,0,32'h0,  1,0,0,0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,  1,0,0,0,0,0));
        vq.push_back(mk(1,1,0,0,32'h0,  1,0,0,0,0,0));
        vq.push_back(mk(1,1,1,0,32'h0,  1,0,1,0,0,0));
        vq.push_back(mk(0,1,1,0,32'h0,  1,1,0,1,0,0));
        // Test 4: fill to DEPTH, full blocks s_req even with a pop
        vq.push_back(mk(1,0,1,0,32'h0,  1,0,1,0,0,0));
        vq.push_back(mk(0,1,1,0,32'h0,  1,1,0,1,0,0));
        vq.push_back(mk(1,0,0,0,32'h0,  0,0,0,0,0,0));
        vq.push_back(mk(1,0,0,1,32'h11, 0,0,0,0,1,0));
        vq.push_back(mk(1,0,1,0,32'h0,  1,0,1,0,0,0));
        // Drain queue d,i,d,i
        vq.push_back(mk(0,0,0,1,32'h21, 0,0,0,0,0,1));
        vq.push_back(mk(0,0,0,1,32'h22, 0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,1,32'h23, 0,0,0,0,0,1));
        vq.push_back(mk(0,0,0,1,32'h24, 0,0,0,0,1,0));
        // Test 5: i,d,d,i outstanding then 0x11..0x44
        vq.push_back(mk(1,0,1,0,32'h0,  1,0,1,0,0,0));
        vq.push_back(mk(0,1,1,0,32'h0,  1,1,0,1,0,0));
        vq.push_back(mk(0,1,1,0,32'h0,  1,1,0,1,0,0));
        vq.push_back(mk(1,0,1,0,32'h0,  1,0,1,0,0,0));
        vq.push_back(mk(0,0,0,1,32'h11, 0,0,0,0,1,0));
        vq.push_back(mk(0,0,0,1,32'h22, 0,0,0,0,0,1));
        vq.push_back(mk(0,0,0,1,32'h33, 0,0,0,0,0,1));
        vq.push_back(mk(0,0,0,1,32'h44, 0,0,0,0,1,0));
        // Push and pop in the same cycle
        vq.push_back(mk(1,0,1,0,32'h0,  1,0,1,0,0,0));
        vq.push_back(mk(0,1,1,1,32'h55, 1,1,0,1,1,0));
        vq.push_back(mk(0,0,0,1,32'h66, 0,0,0,0,0,1));
        vq.push_back(mk(0,0,0,0,32'h0,  0,0,0,0,0,0));

        // Test 1: reset state
        #2;
        chk("rst_s_req", 32'(s_req), 0);
        chk("rst_i_addr_ok", 32'(i_addr_ok), 0);
        chk("rst_d_addr_ok", 32'(d_addr_ok), 0);
        chk("rst_i_data_ok", 32'(i_data_ok), 0);
        chk("rst_d_data_ok", 32'(d_data_ok), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #2;
        chk("idle_s_req", 32'(s_req), 0);
        chk("idle_err", 32'(err), 0);

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].ir, vq[k].dr, vq[k].aok, vq[k].dok, vq[k].rdata);
            #2;
            chk($sformatf("v%0d_s_req", k), 32'(s_req), 32'(vq[k].e_sreq));
            chk($sformatf("v%0d_i_addr_ok", k), 32'(i_addr_ok), 32'(vq[k].e_iaok));
            chk($sformatf("v%0d_d_addr_ok", k), 32'(d_addr_ok), 32'(vq[k].e_daok));
            chk($sformatf("v%0d_i_data_ok", k), 32'(i_data_ok), 32'(vq[k].e_idok));
            chk($sformatf("v%0d_d_data_ok", k), 32'(d_data_ok), 32'(vq[k].e_ddok));
            chk($sformatf("v%0d_err", k), 32'(err), 0);
            if (vq[k].e_sreq) begin
                chk($sformatf("v%0d_s_addr", k), s_addr, vq[k].e_seld ? DA : IA);
                chk($sformatf("v%0d_s_wdata", k), s_wdata, vq[k].e_seld ? DWD : IWD);
                chk($sformatf("v%0d_s_wr", k), 32'(s_wr), vq[k].e_seld ? 32'd1 : 32'd0);
                chk($sformatf("v%0d_s_size", k), 32'(s_size), vq[k].e_seld ? 32'd1 : 32'd2);
            end
            if (vq[k].e_idok) chk($sformatf("v%0d_i_rdata", k), i_rdata, vq[k].rdata);
            if (vq[k].e_ddok) chk($sformatf("v%0d_d_rdata", k), d_rdata, vq[k].rdata);
        end

        // Test 6: stray s_data_ok with empty FIFO sets sticky err
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h77);
        #2;
        chk("stray_i_data_ok", 32'(i_data_ok), 0);
        chk("stray_d_data_ok", 32'(d_data_ok), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, '0);
        #2;
        chk("err_set", 32'(err), 1);
        repeat (3) @(negedge clk);
        #2;
        chk("err_sticky", 32'(err), 1);
        chk("err_no_req", 32'(s_req), 0);
        resetn = 1'b0;
        #2;
        chk("err_cleared", 32'(err), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Unrequested s_addr_ok also flags err
        @(negedge clk);
        drive(0, 0, 1, 0, '0);
        #2;
        chk("stray_aok_i", 32'(i_addr_ok), 0);
        chk("stray_aok_d", 32'(d_addr_ok), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, '0);
        #2;
        chk("err_aok", 32'(err), 1);

        // Reset mid-operation discards outstanding transactions
        drive(1, 0, 1, 0, '0);
        @(negedge clk);
        drive(0, 0, 0, 0, '0);
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h88);
        #2;
        chk("post_rst_i_data_ok", 32'(i_data_ok), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, '0);
        #2;
        chk("post_rst_err", 32'(err), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
